fault_supervisor: RTL

Multi-channel fault qualifier and gate-enable sequencer for the MPPT power stage CPLD. Each raw fault input must be high on QUAL consecutive clock samples before it counts, which rejects the common 1–2 cycle glitches. A qualified fault latches and removes the gate drive. After a holdoff period the block retries automatically, up to MAX_RETRY times, then locks out until an explicit clear.

---
 rtl/fault_supervisor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fault_supervisor.sv
// Fault qualifier and gate-enable sequencer for the MPPT power stage.
// Raw faults must persist QUAL samples before they trip the gates. After a
// trip the block waits out a holdoff and retries automatically, up to
// MAX_RETRY times, then locks out until an explicit clear.
module fault_supervisor #(
    parameter int NCH       = 4,
    parameter int QUAL      = 3,
    parameter int HOLDOFF   = 200,
    parameter int HW        = 8,
    parameter int MAX_RETRY = 3,
    parameter int RW        = 2
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic [NCH-1:0] fault_raw,
    input  logic           enable,
    input  logic           clear,
    output logic           gate_en,
    output logic [NCH-1:0] fault_latched,
    output logic           lockout,
    output logic [RW-1:0]  retry_cnt
);

    localparam int CW = 4;
    localparam logic [CW-1:0] QUAL_SAT  = CW'(QUAL);
    localparam logic [CW-1:0] QUAL_LAST = CW'(QUAL - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, LOCK} state_t;

    state_t                   state_q, state_d;
    logic [NCH-1:0]           s_q;
    logic [NCH-1:0][CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]            holdoff_q, holdoff_d;
    logic [RW-1:0]            retry_q, retry_d;
    logic [NCH-1:0]           latched_q, latched_d;
    logic                     gate_en_q, gate_en_d;
    logic                     lockout_q, lockout_d;
    logic [NCH-1:0]           qual;
    logic                     active;
    logic                     busy;

    // Per-channel run-length counters; qual fires once, on the sample that completes the run
    always_comb begin
        cnt_d  = cnt_q;
        qual   = '0;
        active = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (s_q[i]) begin
                cnt_d[i] = (cnt_q[i] == QUAL_SAT) ? cnt_q[i] : cnt_q[i] + CW'(1);
            end else begin
                cnt_d[i] = '0;
            end
            qual[i] = s_q[i] && (cnt_q[i] == QUAL_LAST);
            if (cnt_q[i] != '0) begin
                active = 1'b1;
            end
        end
        busy = active || (qual != '0);
    end

    // Sequencer: qual beats clear, clear beats holdoff expiry, expiry beats enable
    always_comb begin
        state_d   = state_q;
        holdoff_d = holdoff_q;
        retry_d   = retry_q;
        latched_d = latched_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    latched_d = '0;
                    retry_d   = '0;
                end else if (enable && (latched_q == '0) && (qual == '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (qual != '0) begin
                    state_d   = HOLD;
                    holdoff_d = HOLD_LOAD;
                end else begin
                    if (clear) begin
                        retry_d = '0;
                    end
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (clear) begin
                    state_d   = IDLE;
                    latched_d = '0;
                    retry_d   = '0;
                end else if (holdoff_q == '0) begin
                    if (busy) begin
                        holdoff_d = HOLD_LOAD;
                    end else if (retry_q == RETRY_MAX) begin
                        state_d = LOCK;
                    end else begin
                        retry_d   = retry_q + RW'(1);
                        latched_d = '0;
                        state_d   = RUN;
                    end
                end else if (!enable) begin
                    state_d = IDLE;
                end else begin
                    holdoff_d = holdoff_q - HW'(1);
                end
            end
            LOCK: begin
                if (clear) begin
                    state_d   = IDLE;
                    latched_d = '0;
                    retry_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        latched_d = latched_d | qual;
        gate_en_d = (state_d == RUN);
        lockout_d = (state_d == LOCK);
    end

    // State, sampling and output registers, all cleared at once by reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            s_q       <= '0;
            cnt_q     <= '0;
            holdoff_q <= '0;
            retry_q   <= '0;
            latched_q <= '0;
            gate_en_q <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= fault_raw;
            cnt_q     <= cnt_d;
            holdoff_q <= holdoff_d;
            retry_q   <= retry_d;
            latched_q <= latched_d;
            gate_en_q <= gate_en_d;
            lockout_q <= lockout_d;
        end
    end

    assign gate_en       = gate_en_q;
    assign fault_latched = latched_q;
    assign lockout       = lockout_q;
    assign retry_cnt     = retry_q;

endmodule
